register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter: DATA_W, 32, width of each register and of every data port.
REQ-002 Parameter: ADDR_W, 5, width of every register-address port.
REQ-003 Parameter: NUM_REGS, 32, number of architectural registers; SHALL equal 2**ADDR_W.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-006 Port: RST_N  input  1  asynchronous active-low reset.
REQ-007 Port: RS_ADDR  input  ADDR_W  read-port A register index.
REQ-008 Port: RT_ADDR  input  ADDR_W  read-port B register index.
REQ-009 Port: RS_DATA  output  DATA_W  read-port A data.
REQ-010 Port: RT_DATA  output  DATA_W  read-port B data.
REQ-011 Port: WR_EN  input  1  write strobe, sampled at rising CLK.
REQ-012 Port: WR_ADDR  input  ADDR_W  write register index.
REQ-013 Port: WR_DATA  input  DATA_W  write data.

Function
REQ-014 Storage: NUM_REGS words of DATA_W bits; register 0 SHALL hold no state and SHALL always read 0.
REQ-015 Write: at rising CLK with WR_EN=1 and WR_ADDR!=0, register[WR_ADDR] SHALL take WR_DATA; all other registers SHALL hold.
REQ-016 Write with WR_EN=0, or with WR_ADDR=0, SHALL change no state.
REQ-017 Reads SHALL be combinational, zero-cycle latency: RS_DATA=register[RS_ADDR], RT_DATA=register[RT_ADDR].
REQ-018 Bypass: when WR_EN=1, WR_ADDR!=0 and WR_ADDR equals a read address, that read port SHALL output WR_DATA in the same cycle (write-before-read).
REQ-019 Bypass SHALL apply independently to both read ports; RS_ADDR=RT_ADDR=WR_ADDR SHALL drive WR_DATA on both.
REQ-020 Read address 0 SHALL yield 0 regardless of WR_EN/WR_ADDR/WR_DATA.
REQ-021 Write data SHALL be stored at full DATA_W width with no sign or zero manipulation.
REQ-022 Back-to-back writes to the same register on consecutive cycles SHALL each take effect; last write wins.
REQ-023 X on WR_ADDR/WR_DATA with WR_EN=0 SHALL not corrupt any register.

Reset
REQ-024 RST_N=0 SHALL immediately, without waiting for CLK, clear every register to 0.
REQ-025 During reset RS_DATA and RT_DATA SHALL read 0 for all addresses, and bypass SHALL be suppressed.
REQ-026 Writes SHALL be ignored while RST_N=0, including a CLK edge coincident with reset assertion.
REQ-027 Reset deassertion SHALL be synchronised externally; the first write is accepted at the first rising CLK with RST_N=1.
REQ-028 Reset mid-operation SHALL discard any write presented in that cycle.

Structure
REQ-029 Shared package SHALL hold DATA_W, ADDR_W, NUM_REGS and ZERO_REG=0; the decode/execute stages import the same constants.
REQ-030 One sub-module, reg_word: a DATA_W register with load enable and asynchronous active-low clear; register_file SHALL instantiate NUM_REGS-1 copies (indices 1..31).
REQ-031 Write-address decode (one-hot enables) and the two read multiplexers with bypass SHALL live in register_file.

Verification
REQ-032 Reset: write 0xDEADBEEF to r5, pull RST_N low between edges -> RS_ADDR=5 reads 0x00000000 before next CLK edge.
REQ-033 Zero register: WR_EN=1, WR_ADDR=0, WR_DATA=0xFFFFFFFF, then RS_ADDR=0 -> RS_DATA=0 in that and every later cycle.
REQ-034 Bypass: r7=0x11111111; cycle with WR_EN=1, WR_ADDR=7, WR_DATA=0x22222222, RS_ADDR=RT_ADDR=7 -> both ports read 0x22222222 same cycle, r7=0x22222222 after edge.
REQ-035 Full sweep: write r1..r31 with value 0x1000+i, read every pair (i, 31-i) -> exact values, r0 reads 0.
REQ-036 Disabled write: WR_EN=0, WR_ADDR=3, WR_DATA=0xABCDABCD over 4 edges -> r3 unchanged from prior 0x00000003.
REQ-037 Consecutive writes: r9<=0xA, then r9<=0xB next cycle -> r9 reads 0xA after first edge, 0xB after second.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared constants for the register file and the pipeline stages that index it.
package register_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/register_file_reg_word.sv
// One architectural register: load-enabled word with asynchronous active-low clear.
module reg_word #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ld,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with hardwired zero register and
// write-before-read bypass on both read ports.
module register_file #(
  parameter int DATA_W   = register_file_pkg::DATA_W,
  parameter int ADDR_W   = register_file_pkg::ADDR_W,
  parameter int NUM_REGS = register_file_pkg::NUM_REGS
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] RS_ADDR,
  input  logic [ADDR_W-1:0] RT_ADDR,
  output logic [DATA_W-1:0] RS_DATA,
  output logic [DATA_W-1:0] RT_DATA,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA
);

  import register_file_pkg::*;

  logic [DATA_W-1:0]   w_q [NUM_REGS];
  logic [NUM_REGS-1:1] w_ld;
  logic                w_wr_live;
  logic [DATA_W-1:0]   w_rs_data;
  logic [DATA_W-1:0]   w_rt_data;

  // Register 0 has no storage; it is a constant zero feeding the read muxes.
  assign w_q[0]    = '0;
  assign w_wr_live = WR_EN && (WR_ADDR != ADDR_W'(ZERO_REG));

  always_comb begin
    w_ld = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_ld[i] = w_wr_live && (WR_ADDR == ADDR_W'(i));
    end
  end

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_word
    reg_word #(
      .DATA_W(DATA_W)
    ) u_word (
      .i_clk  (CLK),
      .i_rst_n(RST_N),
      .i_ld   (w_ld[g]),
      .i_d    (WR_DATA),
      .o_q    (w_q[g])
    );
  end

  // Reads are gated by RST_N so both ports show zero and bypass is off in reset.
  always_comb begin
    w_rs_data = '0;
    if (RST_N && (RS_ADDR != ADDR_W'(ZERO_REG))) begin
      if (w_wr_live && (WR_ADDR == RS_ADDR)) begin
        w_rs_data = WR_DATA;
      end else begin
        w_rs_data = w_q[RS_ADDR];
      end
    end
  end

  always_comb begin
    w_rt_data = '0;
    if (RST_N && (RT_ADDR != ADDR_W'(ZERO_REG))) begin
      if (w_wr_live && (WR_ADDR == RT_ADDR)) begin
        w_rt_data = WR_DATA;
      end else begin
        w_rt_data = w_q[RT_ADDR];
      end
    end
  end

  assign RS_DATA = w_rs_data;
  assign RT_DATA = w_rt_data;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected read data,
// a negedge monitor pops and compares.
module tb_register_file;

  logic        CLK;
  logic        RST_N;
  logic [4:0]  RS_ADDR;
  logic [4:0]  RT_ADDR;
  logic [31:0] RS_DATA;
  logic [31:0] RT_DATA;
  logic        WR_EN;
  logic [4:0]  WR_ADDR;
  logic [31:0] WR_DATA;

  typedef struct {
    string       name;
    logic [31:0] rs;
    logic [31:0] rt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  register_file dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .RS_ADDR(RS_ADDR),
    .RT_ADDR(RT_ADDR),
    .RS_DATA(RS_DATA),
    .RT_DATA(RT_DATA),
    .WR_EN  (WR_EN),
    .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One cycle of stimulus, applied 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                      input string name, input logic [31:0] ers, input logic [31:0] ert);
    exp_t e;
    @(posedge CLK);
    #1;
    RST_N   = rst;
    WR_EN   = we;
    WR_ADDR = wa;
    WR_DATA = wd;
    RS_ADDR = ra;
    RT_ADDR = rb;
    e.name = name;
    e.rs   = ers;
    e.rt   = ert;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (RS_DATA !== e.rs) begin
          errors++;
          $display("FAIL %s RS_DATA got %h want %h", e.name, RS_DATA, e.rs);
        end
        checks++;
        if (RT_DATA !== e.rt) begin
          errors++;
          $display("FAIL %s RT_DATA got %h want %h", e.name, RT_DATA, e.rt);
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] ert;
    logic [4:0]  b;
    int          guard;
    RST_N = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0; RS_ADDR = '0; RT_ADDR = '0;

    // Power-on reset: outputs zero, write and bypass suppressed during reset.
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31, "rst_state", 32'h0, 32'h0);
    step(1'b0, 1'b1, 5'd5, 32'h55, 5'd5, 5'd5, "rst_no_bypass", 32'h0, 32'h0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31, "rst_write_ignored", 32'h0, 32'h0);

    // Zero register never takes state.
    step(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "zero_wr_cycle", 32'h0, 32'h0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "zero_after", 32'h0, 32'h0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "zero_later", 32'h0, 32'h0);

    // Sweep writes; RS bypasses the word being written, RT sees earlier writes only.
    for (int i = 1; i < 32; i++) begin
      b = 5'(31 - i);
      if (b == 5'd0)         ert = 32'h0;
      else if (int'(b) < i)  ert = 32'h1000 + 32'(b);
      else                   ert = 32'h0;
      step(1'b1, 1'b1, 5'(i), 32'h1000 + 32'(i), 5'(i), b, "sweep_wr", 32'h1000 + 32'(i), ert);
    end
    for (int i = 0; i < 32; i++) begin
      b = 5'(31 - i);
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), b, "sweep_rd",
           (i == 0) ? 32'h0 : 32'h1000 + 32'(i), (b == 5'd0) ? 32'h0 : 32'h1000 + 32'(b));
    end

    // Disabled writes leave r3 alone, including X on address/data.
    step(1'b1, 1'b1, 5'd3, 32'h3, 5'd0, 5'd0, "r3_init", 32'h0, 32'h0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 5'd3, 32'hABCD_ABCD, 5'd3, 5'd3, "wr_dis", 32'h3, 32'h3);
    step(1'b1, 1'b0, 5'bx, 32'hx, 5'd3, 5'd4, "wr_dis_x", 32'h3, 32'h1004);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd2, "wr_dis_after_x", 32'h3, 32'h1002);

    // Bypass on both ports, then stored value.
    step(1'b1, 1'b1, 5'd7, 32'h1111_1111, 5'd0, 5'd0, "r7_init", 32'h0, 32'h0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, "r7_old", 32'h1111_1111, 32'h1111_1111);
    step(1'b1, 1'b1, 5'd7, 32'h2222_2222, 5'd7, 5'd7, "bypass_both", 32'h2222_2222, 32'h2222_2222);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, "r7_new", 32'h2222_2222, 32'h0);

    // Back-to-back writes to r9: last write wins.
    step(1'b1, 1'b1, 5'd9, 32'hA, 5'd0, 5'd0, "r9_wrA", 32'h0, 32'h0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, "r9_isA", 32'hA, 32'hA);
    step(1'b1, 1'b1, 5'd9, 32'h1, 5'd0, 5'd0, "r9_wr1", 32'h0, 32'h0);
    step(1'b1, 1'b1, 5'd9, 32'hA, 5'd0, 5'd9, "r9_b2b_A", 32'h0, 32'hA);
    step(1'b1, 1'b1, 5'd9, 32'hB, 5'd0, 5'd8, "r9_b2b_B", 32'h0, 32'h1008);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, "r9_isB", 32'hB, 32'h0);

    // Reset mid-operation clears immediately and discards the presented write.
    step(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, "r5_wr", 32'hDEAD_BEEF, 32'h0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, "r5_stored", 32'hDEAD_BEEF, 32'h0);
    step(1'b0, 1'b1, 5'd6, 32'h6666_6666, 5'd5, 5'd6, "rst_mid", 32'h0, 32'h0);
    step(1'b0, 1'b1, 5'd6, 32'h6666_6666, 5'd5, 5'd6, "rst_held", 32'h0, 32'h0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6, "rst_released", 32'h0, 32'h0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31, "rst_cleared", 32'h0, 32'h0);

    // First write after release is accepted.
    step(1'b1, 1'b1, 5'd1, 32'h77, 5'd1, 5'd0, "post_rst_wr", 32'h77, 32'h0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd1, "post_rst_rd", 32'h77, 32'h77);

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge CLK);
      guard++;
    end
    @(posedge CLK);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
